// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a bounded grant hold time.
// Grants are registered, one-hot or zero, separated by at least one idle cycle.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] grant,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q;
    logic [2:0] ptr_q;
    logic [2:0] idx_q;
    logic [7:0] cnt_q;
    logic [7:0] grant_q;
    logic       busy_q;
    logic       timeout_q;
    logic       ready_q;

    logic [7:0] rot_req;
    logic [2:0] pick_off;
    logic       pick_vld;
    logic [2:0] pick_idx;
    logic       rel_done;
    logic       rel_max;

    // Requests rotated so that bit 0 is the current highest-priority requester.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_q + 3'(gi)];
        end
    endgenerate

    always_comb begin
        pick_off = 3'd0;
        pick_vld = 1'b0;
        for (int k = 7; k >= 0; k--) begin
            if (rot_req[k]) begin
                pick_off = 3'(k);
                pick_vld = 1'b1;
            end
        end
    end

    assign pick_idx = ptr_q + pick_off;
    assign rel_done = done || !req[idx_q];
    assign rel_max  = (cnt_q == 8'(HOLD_MAX - 1));

    // ready_q holds off the first grant until one clean edge has passed after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            cnt_q     <= 8'd0;
            grant_q   <= 8'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            ready_q   <= 1'b1;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ready_q && en && pick_vld) begin
                        state_q <= GRANT;
                        idx_q   <= pick_idx;
                        grant_q <= 8'd1 << pick_idx;
                        busy_q  <= 1'b1;
                        cnt_q   <= 8'd0;
                    end
                end
                GRANT: begin
                    if (rel_done || rel_max) begin
                        state_q   <= IDLE;
                        grant_q   <= 8'd0;
                        busy_q    <= 1'b0;
                        ptr_q     <= idx_q + 3'd1;
                        timeout_q <= !rel_done;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule
